// File: rtl/jvo_pulse_seq.sv
// Multi-window pulse sequencer: a free-running period counter drives N_CH outputs,
// each toggled by N_WIN begin/end windows, with optional finite loop count and DONE state.
module jvo_pulse_seq #(
  parameter int N_CH   = 20,
  parameter int N_WIN  = 4,
  parameter int CNT_W  = 32,
  parameter int LOOP_W = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        run,
  input  logic [N_CH*N_WIN*CNT_W-1:0] cnt_beg,
  input  logic [N_CH*N_WIN*CNT_W-1:0] cnt_end,
  input  logic [N_CH-1:0]             io_init,
  input  logic [CNT_W-1:0]            max_count,
  input  logic [LOOP_W-1:0]           n_loops,
  output logic [N_CH-1:0]             io,
  output logic                        trig,
  output logic [LOOP_W-1:0]           loop_cnt,
  output logic [1:0]                  state_o,
  output logic                        done
);

  localparam logic [2:0] ST_DISABLED = 3'd0;
  localparam logic [2:0] ST_PAUSED   = 3'd1;
  localparam logic [2:0] ST_INIT     = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LOOP_W-1:0] LOOP_ONE = {{(LOOP_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r;
  logic [CNT_W-1:0]  count_r;
  logic [LOOP_W-1:0] loop_r;
  logic [N_CH-1:0]   io_r;
  logic              trig_r;
  logic [1:0]        state_o_r;
  logic              done_r;

  logic [N_CH-1:0]   beg_hit_s;
  logic [N_CH-1:0]   end_hit_s;
  logic [N_CH-1:0]   run_io_s;
  logic [2:0]        state_nx_s;
  logic [CNT_W-1:0]  count_nx_s;
  logic [LOOP_W-1:0] loop_nx_s;
  logic [LOOP_W-1:0] loop_inc_s;
  logic [N_CH-1:0]   io_nx_s;
  logic              trig_nx_s;
  logic              last_loop_s;
  logic [1:0]        state_o_nx_s;

  // Window compare per channel; a begin match wins over an end match on the same count.
  always_comb begin
    beg_hit_s = '0;
    end_hit_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < N_WIN; k++) begin
        beg_hit_s[c] = beg_hit_s[c] | (cnt_beg[(c*N_WIN+k)*CNT_W +: CNT_W] == count_r);
        end_hit_s[c] = end_hit_s[c] | (cnt_end[(c*N_WIN+k)*CNT_W +: CNT_W] == count_r);
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      run_io_s[c] = beg_hit_s[c] ? ~io_init[c] : (end_hit_s[c] ? io_init[c] : io_r[c]);
    end
  end

  // Next-state, counter, loop and output computation.
  always_comb begin
    state_nx_s  = state_r;
    count_nx_s  = count_r;
    loop_nx_s   = loop_r;
    io_nx_s     = io_r;
    trig_nx_s   = 1'b0;
    loop_inc_s  = loop_r + LOOP_ONE;
    last_loop_s = (n_loops != {LOOP_W{1'b0}}) && (loop_inc_s == n_loops);
    if (!enable) begin
      state_nx_s = ST_DISABLED;
      count_nx_s = '0;
      loop_nx_s  = '0;
      io_nx_s    = '0;
    end else begin
      case (state_r)
        ST_DISABLED: begin
          state_nx_s = ST_PAUSED;
          count_nx_s = '0;
          loop_nx_s  = '0;
          io_nx_s    = '0;
        end
        ST_PAUSED: begin
          state_nx_s = run ? ST_INIT : ST_PAUSED;
          count_nx_s = '0;
          loop_nx_s  = '0;
          io_nx_s    = '1;
        end
        ST_INIT: begin
          if (!run) begin
            state_nx_s = ST_PAUSED;
            count_nx_s = '0;
            loop_nx_s  = '0;
            io_nx_s    = '1;
          end else begin
            state_nx_s = ST_RUN;
            count_nx_s = '0;
            io_nx_s    = io_init;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state_nx_s = ST_PAUSED;
            count_nx_s = '0;
            loop_nx_s  = '0;
            io_nx_s    = '1;
          end else begin
            trig_nx_s = (count_r == {CNT_W{1'b0}});
            if (count_r == max_count) begin
              count_nx_s = '0;
              if (last_loop_s) begin
                state_nx_s = ST_DONE;
                loop_nx_s  = n_loops;
                io_nx_s    = io_init;
              end else begin
                loop_nx_s  = loop_inc_s;
                io_nx_s    = run_io_s;
              end
            end else begin
              count_nx_s = count_r + CNT_ONE;
              io_nx_s    = run_io_s;
            end
          end
        end
        ST_DONE: begin
          if (!run) begin
            state_nx_s = ST_PAUSED;
            count_nx_s = '0;
            loop_nx_s  = '0;
            io_nx_s    = '1;
          end else begin
            count_nx_s = '0;
            io_nx_s    = io_init;
          end
        end
        default: begin
          state_nx_s = ST_DISABLED;
          count_nx_s = '0;
          loop_nx_s  = '0;
          io_nx_s    = '0;
        end
      endcase
    end
    // INIT is reported as RUN on the external state code.
    case (state_nx_s)
      ST_DISABLED: state_o_nx_s = 2'd0;
      ST_PAUSED:   state_o_nx_s = 2'd1;
      ST_INIT:     state_o_nx_s = 2'd2;
      ST_RUN:      state_o_nx_s = 2'd2;
      ST_DONE:     state_o_nx_s = 2'd3;
      default:     state_o_nx_s = 2'd0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_DISABLED;
      count_r   <= '0;
      loop_r    <= '0;
      io_r      <= '0;
      trig_r    <= 1'b0;
      state_o_r <= 2'd0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      count_r   <= count_nx_s;
      loop_r    <= loop_nx_s;
      io_r      <= io_nx_s;
      trig_r    <= trig_nx_s;
      state_o_r <= state_o_nx_s;
      done_r    <= (state_nx_s == ST_DONE);
    end
  end

  assign io       = io_r;
  assign trig     = trig_r;
  assign loop_cnt = loop_r;
  assign state_o  = state_o_r;
  assign done     = done_r;

endmodule
